// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package riscv_mem_pkg;

   // Default RAM depth; the buffered index width follows from it.
   localparam int unsigned SB_MEM_WORDS = 1024;
   localparam int unsigned IDX_W        = $clog2(SB_MEM_WORDS);

   // Access-size codes (fn3[1:0]); 2'b11 is handled like a word.
   localparam logic [2:0] FN3_B = 3'b000;
   localparam logic [2:0] FN3_H = 3'b001;
   localparam logic [2:0] FN3_W = 3'b010;

   // One pending store: target word, byte enables and lane-replicated data.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [3:0]       be;
      logic [31:0]      data;
   } sb_entry_t;

   // Turn a store into byte enables plus data replicated across all lanes,
   // so the write side never has to shift data.
   function automatic logic [35:0] store_encode(input logic [2:0]  fn3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rs2);
      logic [3:0]  be;
      logic [31:0] data;
      case (fn3[1:0])
         FN3_B[1:0]: begin
            be   = 4'b0001 << off;
            data = {4{rs2[7:0]}};
         end
         FN3_H[1:0]: begin
            be   = off[1] ? 4'b1100 : 4'b0011;
            data = {2{rs2[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            data = rs2;
         end
      endcase
      return {be, data};
   endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store buffer; exposes its entries oldest-first with a valid mask.
module sb_fifo
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push_i,
   input  sb_entry_t                     entry_i,
   input  logic                          pop_i,
   output sb_entry_t [DEPTH-1:0]         ord_o,
   output logic [DEPTH-1:0]              valid_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic                          full_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   sb_entry_t        slot_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // Never overfill or underflow, whatever the caller asks for.
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & (count_q != '0);
   assign count_o = count_q;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   // Entry storage needs no reset: the valid mask hides stale slots.
   always_ff @(posedge clk) begin
      if (do_push) slot_q[tail_q] <= entry_i;
   end

   // Age-ordered view: position 0 is the head (oldest) entry.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_view
         assign ord_o[gi]   = slot_q[head_q + PTR_W'(gi)];
         assign valid_o[gi] = (count_q > (PTR_W+1)'(gi));
      end
   endgenerate

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory stage: store buffer draining into a word RAM, with
// store-to-load forwarding so buffered stores are visible immediately.
// MEM_WORDS must agree with SB_MEM_WORDS, which sizes the buffered index.
module dmem_store_buffer
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MEM_WORDS = SB_MEM_WORDS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            address,
   input  logic [31:0]            rs2_data,
   input  logic [2:0]             fn3,
   input  logic                   mem_read,
   input  logic                   mem_write,
   output logic [31:0]            mem_out,
   output logic                   stall,
   output logic                   misalign,
   output logic [$clog2(DEPTH):0] sb_count
);

   logic [31:0]           ram_q [MEM_WORDS];
   logic [IDX_W-1:0]      idx;
   logic [1:0]            off;
   logic [35:0]           enc;
   sb_entry_t             new_e;
   sb_entry_t             head_e;
   sb_entry_t [DEPTH-1:0] fifo_ord;
   logic [DEPTH-1:0]      fifo_valid;
   logic                  fifo_full;
   logic                  push;
   logic                  drain;
   logic [31:0]           load_word;
   logic                  unused_addr_bits;

   // Upper address bits are ignored so addresses wrap onto the RAM.
   assign idx              = address[IDX_W+1:2];
   assign off              = address[1:0];
   assign unused_addr_bits = ^address[31:IDX_W+2];

   assign enc   = store_encode(fn3, off, rs2_data);
   assign new_e = '{idx: idx, be: enc[35:32], data: enc[31:0]};

   // Halfwords need even addresses; words (and fn3=11) need word alignment.
   assign misalign = mem_write &
                     (((fn3[1:0] == FN3_H[1:0]) & off[0]) |
                      (fn3[1] & (off != 2'b00)));
   // Full buffer refuses stores outright, even if it drains this cycle.
   assign stall = mem_write & fifo_full & ~misalign;
   assign push  = mem_write & ~stall & ~misalign;
   // The single RAM port is free only when no load is using it.
   assign drain = ~reset & (sb_count != '0) & ~mem_read;

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .entry_i (new_e),
      .pop_i   (drain),
      .ord_o   (fifo_ord),
      .valid_o (fifo_valid),
      .count_o (sb_count),
      .full_o  (fifo_full)
   );

   assign head_e = fifo_ord[0];

   // Retire the oldest buffered store into RAM with byte enables.
   always_ff @(posedge clk) begin
      if (drain) begin
         for (int k = 0; k < 4; k++) begin
            if (head_e.be[k]) ram_q[head_e.idx][8*k +: 8] <= head_e.data[8*k +: 8];
         end
      end
   end

   // Load path: RAM word overlaid by buffered bytes, oldest first so the youngest wins.
   always_comb begin
      load_word = ram_q[idx];
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i] && (fifo_ord[i].idx == idx)) begin
            for (int k = 0; k < 4; k++) begin
               if (fifo_ord[i].be[k]) load_word[8*k +: 8] = fifo_ord[i].data[8*k +: 8];
            end
         end
      end
      mem_out = (mem_read & ~mem_write) ? load_word : 32'h0;
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, reset corner case,
// then randomized traffic against an architectural memory model.
module tb_dmem_store_buffer;
   import riscv_mem_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] rs2_data;
   logic [2:0]  fn3;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_out;
   logic        stall;
   logic        misalign;
   logic [2:0]  sb_count;

   int total = 0;
   int bad   = 0;

   dmem_store_buffer #(.DEPTH(DEPTH), .MEM_WORDS(1024)) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .rs2_data  (rs2_data),
      .fn3       (fn3),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_out   (mem_out),
      .stall     (stall),
      .misalign  (misalign),
      .sb_count  (sb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] out;
      logic        st;
      logic        mis;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic rd, input logic wr, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] out,
                      input logic st, input logic mis, input logic [2:0] cnt);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f = f; v.a = a; v.d = d;
      v.out = out; v.st = st; v.mis = mis; v.cnt = cnt;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later.
   task automatic drive(input logic rd, input logic wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_read = rd; mem_write = wr; fn3 = f; address = a; rs2_data = d;
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] out, input logic st,
                            input logic mis, input logic [2:0] cnt);
      check({tag, ".mem_out"},  mem_out,         out);
      check({tag, ".stall"},    {31'b0, stall},    {31'b0, st});
      check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, mis});
      check({tag, ".sb_count"}, {29'b0, sb_count}, {29'b0, cnt});
   endtask

   // Architectural model: memory as the program-order result of all accepted
   // stores (buffering must be invisible to loads) plus an occupancy count.
   logic [7:0] amem [8][4];
   int         mcnt;

   task automatic model_step(input logic rd, input logic wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] d, input int n);
      int          w;
      int          o;
      logic        mis, st, pushed, drained;
      logic [31:0] out;
      w   = (a[11:2] - 10'd64);
      o   = a[1:0];
      mis = wr && ((f[1:0] == 2'b01 && o % 2 == 1) || (f[1] && o != 0));
      st  = wr && (mcnt == DEPTH) && !mis;
      out = (rd && !wr) ? {amem[w][3], amem[w][2], amem[w][1], amem[w][0]} : 32'h0;
      drive(rd, wr, f, a, d);
      $display("rand %0d rd=%0b wr=%0b fn3=%0d addr=%h data=%h out=%h cnt=%0d",
               n, rd, wr, f, a, d, mem_out, sb_count);
      check_all($sformatf("rand%0d", n), out, st, mis, 3'(mcnt));
      pushed  = wr && !mis && !st;
      drained = (mcnt != 0) && !rd;
      if (pushed) begin
         case (f[1:0])
            2'b00: amem[w][o] = d[7:0];
            2'b01: begin
               amem[w][(o/2)*2]     = d[7:0];
               amem[w][(o/2)*2 + 1] = d[15:8];
            end
            default: for (int b = 0; b < 4; b++) amem[w][b] = d[8*b +: 8];
         endcase
      end
      mcnt = mcnt + (pushed ? 1 : 0) - (drained ? 1 : 0);
   endtask

   initial begin
      // Directed vectors: rd wr fn3 addr data | mem_out stall misalign count-before-edge
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd0); // idle after reset
      add(0,1,3'd2,32'h10,32'h11223344, 32'h0,        0,0,3'd0); // sw
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd1); // drain
      add(1,0,3'd2,32'h10,32'h0,        32'h11223344, 0,0,3'd0); // lw from RAM
      add(0,1,3'd2,32'h20,32'hDEADBEEF, 32'h0,        0,0,3'd0);
      add(1,0,3'd2,32'h20,32'h0,        32'hDEADBEEF, 0,0,3'd1); // forwarded
      add(0,1,3'd2,32'h30,32'h0,        32'h0,        0,0,3'd1); // push+drain
      add(1,0,3'd2,32'h30,32'h0,        32'h0,        0,0,3'd1);
      add(0,1,3'd0,32'h31,32'h000000AB, 32'h0,        0,0,3'd1); // sb
      add(1,0,3'd2,32'h30,32'h0,        32'h0000AB00, 0,0,3'd1);
      add(0,1,3'd1,32'h32,32'h0000CDEF, 32'h0,        0,0,3'd1); // sh
      add(1,0,3'd2,32'h30,32'h0,        32'hCDEFAB00, 0,0,3'd1); // in buffer
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd1);
      add(1,0,3'd2,32'h30,32'h0,        32'hCDEFAB00, 0,0,3'd0); // after drain
      add(1,0,3'd5,32'h32,32'h0,        32'hCDEFAB00, 0,0,3'd0); // lhu: whole word
      add(1,1,3'd2,32'h40,32'd1,        32'h0,        0,0,3'd0); // fill, no drain
      add(1,1,3'd2,32'h40,32'd2,        32'h0,        0,0,3'd1);
      add(1,1,3'd2,32'h40,32'd3,        32'h0,        0,0,3'd2);
      add(1,1,3'd2,32'h40,32'd4,        32'h0,        0,0,3'd3);
      add(1,1,3'd2,32'h40,32'd5,        32'h0,        1,0,3'd4); // full -> stall
      add(1,0,3'd2,32'h40,32'h0,        32'd4,        0,0,3'd4); // youngest wins
      add(0,1,3'd2,32'h44,32'd5,        32'h0,        1,0,3'd4); // stall, drain one
      add(0,1,3'd2,32'h44,32'd5,        32'h0,        0,0,3'd3); // accepted
      add(1,0,3'd2,32'h40,32'h0,        32'd4,        0,0,3'd3);
      add(1,0,3'd2,32'h44,32'h0,        32'd5,        0,0,3'd3);
      add(1,1,3'd1,32'h41,32'h7777,     32'h0,        0,1,3'd3); // misaligned sh
      add(1,1,3'd2,32'h42,32'h7777,     32'h0,        0,1,3'd3); // misaligned sw
      add(1,0,3'd2,32'h40,32'h0,        32'd4,        0,0,3'd3);
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd3);
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd2);
      add(0,0,3'd0,32'h00,32'h0,        32'h0,        0,0,3'd1);
      add(1,0,3'd2,32'h40,32'h0,        32'd4,        0,0,3'd0); // RAM untouched by misaligned
      add(1,0,3'd2,32'h44,32'h0,        32'd5,        0,0,3'd0);
      add(0,1,3'd0,32'h23,32'h12345699, 32'h0,        0,0,3'd0); // sb byte 3
      add(1,0,3'd2,32'h20,32'h0,        32'h99ADBEEF, 0,0,3'd1);
      add(0,1,3'd3,32'h24,32'h0000A5A5, 32'h0,        0,0,3'd1); // fn3=11 as word
      add(1,0,3'd2,32'h24,32'h0,        32'h0000A5A5, 0,0,3'd1);
      add(0,1,3'd3,32'h26,32'h11111111, 32'h0,        0,1,3'd1); // fn3=11 misaligned
      add(1,0,3'd2,32'h24,32'h0,        32'h0000A5A5, 0,0,3'd0);
      add(1,0,3'd2,32'h20,32'h0,        32'h99ADBEEF, 0,0,3'd0);

      reset = 1'b1; mem_read = 0; mem_write = 0; fn3 = 0; address = 0; rs2_data = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].rd, tv[i].wr, tv[i].f, tv[i].a, tv[i].d);
         $display("vec %0d rd=%0b wr=%0b fn3=%0d addr=%h data=%h out=%h stall=%0b mis=%0b cnt=%0d",
                  i, tv[i].rd, tv[i].wr, tv[i].f, tv[i].a, tv[i].d, mem_out, stall, misalign, sb_count);
         check_all($sformatf("vec%0d", i), tv[i].out, tv[i].st, tv[i].mis, tv[i].cnt);
      end

      // Reset with three stores pending and a drain due on the same edge.
      drive(0,1,3'd2,32'h50,32'h55);   check("rst.pre0", {29'b0, sb_count}, 32'd0);
      drive(0,0,3'd0,32'h0,32'h0);     check("rst.pre1", {29'b0, sb_count}, 32'd1);
      drive(1,1,3'd2,32'h50,32'h66);
      drive(1,1,3'd2,32'h50,32'h77);
      drive(1,1,3'd2,32'h50,32'h88);
      drive(0,0,3'd0,32'h0,32'h0);
      reset = 1'b1;
      check("rst.full", {29'b0, sb_count}, 32'd3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      $display("reset mid-drain: cnt=%0d stall=%0b mis=%0b out=%h", sb_count, stall, misalign, mem_out);
      check_all("rst.after", 32'h0, 1'b0, 1'b0, 3'd0);
      drive(1,0,3'd2,32'h50,32'h0);
      $display("lw after reset: out=%h", mem_out);
      check("rst.lw", mem_out, 32'h55);

      // Randomized traffic over words 64..71 with random aliasing upper bits.
      mcnt = 0;
      for (int w = 0; w < 8; w++)
         model_step(1'b0, 1'b1, 3'd2, 32'h100 + 32'(w*4), 32'h0, w);
      for (int n = 8; n < 408; n++) begin
         int          r;
         logic        rd, wr;
         logic [2:0]  f;
         logic [31:0] a;
         r  = $urandom_range(0, 9);
         rd = (r >= 4 && r <= 8);
         wr = (r <= 5);
         if (wr) f = 3'($urandom_range(0, 3));
         else begin
            int fs;
            fs = $urandom_range(0, 4);
            f  = (fs < 3) ? 3'(fs) : 3'(fs + 1);
         end
         a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3))
             + (32'($urandom_range(0, 7)) << 16);
         model_step(rd, wr, f, a, $urandom, n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
